// File: rtl/cache_arbiter_pkg.sv
// cache_arbiter_pkg
// Shared types for the LC-3b memory-port arbiter: the cache line type,
// the arbiter FSM state encoding and the requester identifier.
// No ports; imported by arb_select and cache_arbiter.
// Optional feature macro used by the importing files: CACHE_ARBITER_RR_EN.
package cache_arbiter_pkg;

  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  typedef enum logic {
    ARB_I = 1'b0,
    ARB_D = 1'b1
  } arb_src_t;

  // Maps a winning requester onto the busy state that serves it.
  function automatic arb_state_t busyStateFor(input arb_src_t src);
    return (src == ARB_D) ? D_BUSY : I_BUSY;
  endfunction

endpackage

// File: rtl/cache_arbiter_select.sv
// arb_select
// Purely combinational winner selection between the I-cache and D-cache.
// Ports:
//   i_req       in   I-cache has a pending request
//   d_req       in   D-cache has a pending request (read or write)
//   last_grant  in   requester served most recently (used only in RR mode)
//   grant_valid out  at least one requester is pending
//   grant_src   out  requester that wins this cycle
// Macro CACHE_ARBITER_RR_EN: when defined, ties go to the requester that
// was not served last; otherwise the D-cache always wins ties.
module arb_select
  import cache_arbiter_pkg::*;
(
  input  logic     i_req,
  input  logic     d_req,
  input  arb_src_t last_grant,
  output logic     grant_valid,
  output arb_src_t grant_src
);

  assign grant_valid = i_req | d_req;

`ifdef CACHE_ARBITER_RR_EN
  // Round-robin: a lone requester always wins, a tie alternates away
  // from whoever was served last, bounding each cache's wait to one
  // foreign transaction.
  always_comb begin
    grant_src = ARB_I;
    if (i_req && d_req) begin
      grant_src = (last_grant == ARB_I) ? ARB_D : ARB_I;
    end else if (d_req) begin
      grant_src = ARB_D;
    end
  end
`else
  // Fixed priority: the D-cache wins whenever it is asking. The history
  // input is consumed here only so the port list stays identical in
  // both builds.
  logic unusedLastGrant;
  assign unusedLastGrant = last_grant;

  assign grant_src = d_req ? ARB_D : ARB_I;
`endif

endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter
// Shares the single physical-memory port between the I-cache miss path and
// the D-cache miss/writeback path. One requester is granted at a time; its
// address, write data and operation are registered and held on the memory
// side until pmem_resp, which is then returned to that requester only.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   i_read, i_addr              I-cache line-fill request and address
//   i_rdata, i_resp             I-cache fill data and completion pulse
//   d_read, d_write, d_addr     D-cache fill / writeback request and address
//   d_wdata                     D-cache writeback line
//   d_rdata, d_resp             D-cache fill data and completion pulse
//   pmem_read, pmem_write       registered memory strobes
//   pmem_address, pmem_wdata    registered memory address and write line
//   pmem_rdata, pmem_resp       memory read data and completion pulse
// Macro CACHE_ARBITER_RR_EN: enables round-robin tie breaking with a
// last-grant flop; undefined gives fixed D-cache priority.
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              read_q, read_d;
  logic              write_q, write_d;

  logic              dReq;
  logic              grantValid;
  arb_src_t          grantSrc;
  arb_src_t          lastGrant;
  logic              granting;

  // A simultaneous d_read/d_write is illegal; it falls through as a write
  // because d_write alone decides the latched operation below.
  assign dReq     = d_read | d_write;
  assign granting = (state_q == IDLE) && grantValid;

`ifdef CACHE_ARBITER_RR_EN
  arb_src_t lastGrant_q;

  // Remembers who was served last so ties alternate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lastGrant_q <= ARB_I;
    end else if (granting) begin
      lastGrant_q <= grantSrc;
    end
  end

  assign lastGrant = lastGrant_q;
`else
  assign lastGrant = ARB_I;
`endif

  arb_select uSelect (
    .i_req       (i_read),
    .d_req       (dReq),
    .last_grant  (lastGrant),
    .grant_valid (grantValid),
    .grant_src   (grantSrc)
  );

  // Next-state logic. The strobes are computed here and registered so the
  // memory side never sees a decoded, glitchy strobe. Requester inputs are
  // only looked at in IDLE; while busy everything comes from the latches.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    read_d  = read_q;
    write_d = write_q;
    case (state_q)
      IDLE: begin
        if (granting) begin
          state_d = busyStateFor(grantSrc);
          if (grantSrc == ARB_D) begin
            addr_d  = d_addr;
            read_d  = ~d_write;
            write_d = d_write;
            if (d_write) begin
              wdata_d = d_wdata;
            end
          end else begin
            addr_d  = i_addr;
            read_d  = 1'b1;
            write_d = 1'b0;
          end
        end
      end
      I_BUSY, D_BUSY: begin
        if (pmem_resp) begin
          state_d = DONE;
          read_d  = 1'b0;
          write_d = 1'b0;
        end
      end
      DONE: begin
        // One quiet cycle lets the served cache drop its request before
        // the next arbitration in IDLE.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  // State and memory-side registers; reset abandons any in-flight access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      read_q  <= read_d;
      write_q <= write_d;
    end
  end

  assign pmem_read    = read_q;
  assign pmem_write   = write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  // Responses are routed combinationally in the pmem_resp cycle, so the
  // arbiter adds no latency; read data is shared and qualified by resp.
  assign i_resp  = (state_q == I_BUSY) && pmem_resp;
  assign d_resp  = (state_q == D_BUSY) && pmem_resp;
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter
// Self-checking bench for cache_arbiter. A transaction-level model tracks
// which caches are pending and picks the winner from the arbitration rules
// (fixed D priority, or alternating ties when CACHE_ARBITER_RR_EN is
// defined); each served transaction is checked cycle by cycle against it.
module tb_cache_arbiter;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;

  logic              clk;
  logic              reset;
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_read       (i_read),
    .i_addr       (i_addr),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending requests, last latched write line, last winner.
  bit                iPend;
  bit                dPend;
  bit                dIsWrite;
  logic [ADDR_W-1:0] iAddrM;
  logic [ADDR_W-1:0] dAddrM;
  logic [LINE_W-1:0] dDataM;
  logic [LINE_W-1:0] lastWdataM;
  bit                lastWasD;
  logic [5:0]        orderBits;

  // The D-cache must never raise both read and write together.
  always @(negedge clk) begin
    if (!reset) begin
      assert (!(d_read && d_write)) else begin
        errors++;
        $error("[TB] FAIL illegal_d_rw: observed read=%0b write=%0b expected not both", d_read, d_write);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] randLine();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic applyStimulusI(input logic [ADDR_W-1:0] a);
    iPend  = 1'b1;
    iAddrM = a;
    i_read = 1'b1;
    i_addr = a;
  endtask

  task automatic applyStimulusD(input bit wr, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] dat);
    dPend    = 1'b1;
    dIsWrite = wr;
    dAddrM   = a;
    dDataM   = dat;
    d_read   = !wr;
    d_write  = wr;
    d_addr   = a;
    d_wdata  = dat;
  endtask

  // Winner chosen from the arbitration rules, not from any DUT state.
  function automatic bit modelPicksD();
    if (iPend && dPend) begin
`ifdef CACHE_ARBITER_RR_EN
      return !lastWasD;
`else
      return 1'b1;
`endif
    end
    return dPend;
  endfunction

  // Serves one transaction starting from an IDLE cycle with requests
  // already driven: grant on the next edge, lat quiet BUSY cycles, the
  // response cycle, DONE, then an IDLE cycle with the winner still holding.
  task automatic serveOne(input int lat, input logic [LINE_W-1:0] rdata);
    bit                winD;
    bit                expWr;
    logic [ADDR_W-1:0] expAddr;
    logic [LINE_W-1:0] doneData;
    winD    = modelPicksD();
    expAddr = winD ? dAddrM : iAddrM;
    expWr   = winD && dIsWrite;
    if (expWr) lastWdataM = dDataM;
    lastWasD = winD;
    tick();
    for (int k = 0; k <= lat; k++) begin
      if (k == lat) begin
        pmem_rdata = rdata;
        pmem_resp  = 1'b1;
      end else begin
        if (winD) begin
          d_addr  = ADDR_W'($urandom);
          d_wdata = randLine();
          if (!iPend && $urandom_range(0, 2) == 0) applyStimulusI(ADDR_W'($urandom));
        end else begin
          i_addr = ADDR_W'($urandom);
          if (!dPend && $urandom_range(0, 2) == 0)
            applyStimulusD(1'($urandom_range(0, 1)), ADDR_W'($urandom), randLine());
        end
      end
      #1;
      checkOutput("busy_pmem_read", pmem_read, !expWr);
      checkOutput("busy_pmem_write", pmem_write, expWr);
      checkOutput("busy_pmem_address", pmem_address, expAddr);
      checkOutput("busy_pmem_wdata", pmem_wdata, lastWdataM);
      checkOutput("busy_i_resp", i_resp, (k == lat) && !winD);
      checkOutput("busy_d_resp", d_resp, (k == lat) && winD);
      if (k == lat) begin
        checkOutput("resp_rdata", winD ? d_rdata : i_rdata, rdata);
        orderBits = {orderBits[4:0], d_resp};
      end
      tick();
    end
    // DONE: memory may still show resp; nothing must be forwarded.
    pmem_resp  = 1'($urandom_range(0, 1));
    doneData   = randLine();
    pmem_rdata = doneData;
    #1;
    checkOutput("done_pmem_read", pmem_read, 1'b0);
    checkOutput("done_pmem_write", pmem_write, 1'b0);
    checkOutput("done_i_resp", i_resp, 1'b0);
    checkOutput("done_d_resp", d_resp, 1'b0);
    checkOutput("done_i_rdata_passthru", i_rdata, doneData);
    checkOutput("done_d_rdata_passthru", d_rdata, doneData);
    tick();
    pmem_resp = 1'b0;
    #1;
    // Winner held its request through DONE; it must not be re-granted.
    checkOutput("idle_pmem_read", pmem_read, 1'b0);
    checkOutput("idle_pmem_write", pmem_write, 1'b0);
    if (winD) begin
      dPend   = 1'b0;
      d_read  = 1'b0;
      d_write = 1'b0;
    end else begin
      iPend  = 1'b0;
      i_read = 1'b0;
    end
  endtask

  initial begin
    reset      = 1'b1;
    i_read     = 1'b0;
    i_addr     = '0;
    d_read     = 1'b0;
    d_write    = 1'b0;
    d_addr     = '0;
    d_wdata    = '0;
    pmem_resp  = 1'b0;
    pmem_rdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    iPend      = 1'b0;
    dPend      = 1'b0;
    dIsWrite   = 1'b0;
    iAddrM     = '0;
    dAddrM     = '0;
    dDataM     = '0;
    lastWdataM = '0;
    lastWasD   = 1'b0;
    orderBits  = '0;

    // Reset values
    tick();
    tick();
    checkOutput("rst_pmem_read", pmem_read, 1'b0);
    checkOutput("rst_pmem_write", pmem_write, 1'b0);
    checkOutput("rst_pmem_address", pmem_address, '0);
    checkOutput("rst_pmem_wdata", pmem_wdata, '0);
    checkOutput("rst_i_resp", i_resp, 1'b0);
    checkOutput("rst_d_resp", d_resp, 1'b0);
    checkOutput("rst_i_rdata", i_rdata, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    checkOutput("rst_d_rdata", d_rdata, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    reset = 1'b0;
    tick();

    // Lone I-fill, memory answers on the fifth busy cycle
    $display("[TB] lone I-fill");
    applyStimulusI(16'h1230);
    serveOne(4, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF);

    // D writeback with wandering inputs while busy
    $display("[TB] D writeback");
    applyStimulusD(1'b1, 16'h8000, {4{32'hA5A5A5A5}});
    serveOne(3, randLine());

    // Simultaneous read requests: D first, I two cycles after d_resp
    $display("[TB] simultaneous requests");
    applyStimulusI(16'h0100);
    applyStimulusD(1'b0, 16'h0200, randLine());
    serveOne(2, randLine());
    serveOne(1, randLine());

    // Zero-wait memory
    $display("[TB] zero-wait memory");
    applyStimulusD(1'b0, 16'h3000, randLine());
    serveOne(0, randLine());

    // Reset in the middle of a D writeback with memory responding
    $display("[TB] reset mid D_BUSY");
    applyStimulusD(1'b1, 16'h4440, randLine());
    tick();
    #1;
    checkOutput("prerst_pmem_write", pmem_write, 1'b1);
    pmem_resp = 1'b1;
    reset     = 1'b1;
    #1;
    checkOutput("midrst_pmem_read", pmem_read, 1'b0);
    checkOutput("midrst_pmem_write", pmem_write, 1'b0);
    checkOutput("midrst_i_resp", i_resp, 1'b0);
    checkOutput("midrst_d_resp", d_resp, 1'b0);
    checkOutput("midrst_pmem_address", pmem_address, '0);
    checkOutput("midrst_pmem_wdata", pmem_wdata, '0);
    d_read     = 1'b0;
    d_write    = 1'b0;
    pmem_resp  = 1'b0;
    dPend      = 1'b0;
    iPend      = 1'b0;
    lastWasD   = 1'b0;
    lastWdataM = '0;
    tick();
    reset = 1'b0;
    tick();
    applyStimulusI(16'h0040);
    serveOne(2, randLine());

    // Repeated ties right after reset history: D, I, D, I, D, I
    $display("[TB] repeated ties");
    orderBits = '0;
    for (int r = 0; r < 3; r++) begin
      applyStimulusI(16'h0500 + 16'(r));
      applyStimulusD(1'b0, 16'h0600 + 16'(r), randLine());
      serveOne(1, randLine());
      serveOne(0, randLine());
    end
    checkOutput("tie_grant_order", orderBits, 6'b101010);

    // Randomized traffic
    $display("[TB] random traffic");
    for (int n = 0; n < 40; n++) begin
      if (!iPend && $urandom_range(0, 1) == 1) applyStimulusI(ADDR_W'($urandom));
      if (!dPend && $urandom_range(0, 1) == 1)
        applyStimulusD(1'($urandom_range(0, 1)), ADDR_W'($urandom), randLine());
      if (!iPend && !dPend) applyStimulusI(ADDR_W'($urandom));
      serveOne($urandom_range(0, 3), randLine());
    end
    for (int n = 0; n < 2; n++) begin
      if (iPend || dPend) serveOne($urandom_range(0, 2), randLine());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Shares the single physical-memory port between the I-cache miss path and the D-cache miss/writeback path of the pipelined LC-3b core. It sits between the two caches and physical memory. It grants one requester at a time, registers the winning request, and holds it stable on the memory side until the memory responds. It then returns the response to the winner only.

## Interface
Parameters:
- ADDR_W, 16, byte address width
- LINE_W, 128, cache line width in bits

Ports (clock and reset: clk; reset, asynchronous, active-high):
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- i_read  in  1  I-cache line-fill request, held until i_resp
- i_addr  in  ADDR_W  I-cache line address
- i_rdata  out  LINE_W  fill data, valid when i_resp
- i_resp  out  1  one-cycle completion pulse to I-cache
- d_read  in  1  D-cache line-fill request, held until d_resp
- d_write  in  1  D-cache writeback request, held until d_resp
- d_addr  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_W  writeback line
- d_rdata  out  LINE_W  fill data, valid when d_resp
- d_resp  out  1  one-cycle completion pulse to D-cache
- pmem_read  out  1  physical memory read strobe
- pmem_write  out  1  physical memory write strobe
- pmem_address  out  ADDR_W  registered line address
- pmem_wdata  out  LINE_W  registered writeback line
- pmem_rdata  in  LINE_W  memory read data
- pmem_resp  in  1  memory completion pulse

## Operation
- States: IDLE, I_BUSY, D_BUSY, DONE.
- IDLE:
  - If no request is pending, stay in IDLE.
  - If a request is pending, select the winner and latch its address into addr_q. For a D-cache write, also latch d_wdata into wdata_q and latch op (read/write). Go to I_BUSY or D_BUSY.
- I_BUSY / D_BUSY:
  - pmem_read/pmem_write are driven from the latched op. pmem_address = addr_q and pmem_wdata = wdata_q.
  - Requester inputs are ignored after latching.
  - On pmem_resp: assert i_resp or d_resp combinationally in that same cycle. Pass pmem_rdata through to the winner's rdata. Go to DONE.
- DONE: strobes and resps are low for exactly one cycle, so the served requester can drop its request. Return to IDLE.
- d_read and d_write asserted together is illegal. If it occurs, treat it as a write; the bench flags it with an assertion.
- Tie (i_read and a D request both pending in IDLE): fixed D priority, unless CACHE_ARBITER_RR_EN is defined (see Configuration).
- A request that appears during BUSY/DONE waits. It is never dropped and never merged.
- i_rdata and d_rdata equal pmem_rdata at all times; only the resp qualifies them.
- Reset at any point:
  - State goes to IDLE immediately.
  - All strobes and resps are driven 0.
  - addr_q and wdata_q are set to 0.
  - last_grant is set to I.
  - An in-flight memory transaction is abandoned; memory must also be reset.

## Timing
- Reset values: pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, i_resp=0, d_resp=0. i_rdata and d_rdata follow pmem_rdata.
- Grant latency: a request sampled in IDLE at edge N gives a memory strobe high from cycle N+1.
- Response latency: i_resp or d_resp is in the same cycle as pmem_resp (zero added latency).
- Minimum occupancy: 3 cycles per transaction (IDLE, BUSY with immediate pmem_resp, DONE).
- Back-to-back: the second requester's strobe rises 2 cycles after the first resp (DONE, IDLE).
- The memory-side address, data and strobe are glitch-free registered outputs, stable for the whole BUSY state.

## Configuration
- Macro: CACHE_ARBITER_RR_EN.
- Defined:
  - A last_grant flop updates at each grant.
  - On a tie, the requester not served last wins.
  - A lone requester always wins.
  - This guarantees neither cache waits more than one foreign transaction.
- Undefined: the D-cache always wins ties. No last_grant flop exists.

## Structure
- Add to lc3b_types:
  - typedef lc3b_line (logic [127:0])
  - enum arb_state_t {IDLE, I_BUSY, D_BUSY, DONE}
  - enum arb_src_t {ARB_I, ARB_D}
- One combinational sub-module, arb_select. Inputs: i_req, d_req, last_grant. Outputs: grant_valid, grant_src. Contains the RR/fixed logic under the macro.
- The top level holds the FSM, the addr_q/wdata_q/op registers and the output muxing.

## Test plan
- Reset mid-D_BUSY: assert reset while pmem_write=1 -> all strobes and resps are 0 in the same cycle; state is IDLE. After release, i_read at 0x0040 is granted normally.
- Lone I-fill: i_read, addr 0x1230; memory answers after 5 cycles with 0xDEADBEEF_... -> pmem_read=1 and pmem_address=0x1230 from cycle +1. The i_resp pulse coincides with pmem_resp, i_rdata matches, d_resp stays 0.
- D writeback: d_write, addr 0x8000, wdata 0xA5A5...; d_addr and d_wdata change mid-BUSY -> pmem_address and pmem_wdata stay 0x8000 and 0xA5A5... until pmem_resp.
- Simultaneous i_read and d_read, fixed mode -> D served first and I served second. I's strobe rises exactly 2 cycles after d_resp.
- Simultaneous requests repeated 3 times with CACHE_ARBITER_RR_EN defined and last_grant=I after reset -> grant order D, I, D, I, D, I.
- Zero-wait memory (pmem_resp in the first BUSY cycle) -> 3-cycle occupancy. No double resp; a held request is not re-granted in DONE.
